// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : fetch, data and memory-side signals of the memory arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic [15:0] if_rdata_o;
  logic        if_done_o;
  logic        if_stall_o;

  logic        dm_req_i;
  logic        dm_wr_i;
  logic [15:0] dm_addr_i;
  logic [15:0] dm_wdata_i;
  logic [15:0] dm_rdata_o;
  logic        dm_done_o;
  logic        dm_stall_o;

  logic        mem_en_o;
  logic        mem_wr_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_done_i;
  logic        err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_done_o, if_stall_o,
    input  dm_req_i, dm_wr_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_done_o, dm_stall_o,
    output mem_en_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_done_i,
    output err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_done_o, if_stall_o,
    output dm_req_i, dm_wr_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_done_o, dm_stall_o,
    input  mem_en_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_done_i,
    input  err_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : alternating fetch/data arbiter for a single-ported memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_DM_WAIT = 2'd1;
  localparam logic [1:0] c_IF_WAIT = 2'd2;
  localparam logic [1:0] c_ERR     = 2'd3;
  localparam logic       c_FETCH   = 1'b0;
  localparam logic       c_DATA    = 1'b1;
  localparam logic [7:0] c_WAIT_LIMIT = 8'(MAX_WAIT - 1);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        err_q, err_d;

  logic w_if_elig, w_dm_elig, w_grant_if, w_grant_dm;

  // A requester in its done cycle still shows req=1; mask it so it cannot re-win.
  assign w_if_elig  = bus.if_req_i & ~if_done_q;
  assign w_dm_elig  = bus.dm_req_i & ~dm_done_q;
  assign w_grant_dm = (state_q == c_IDLE) & w_dm_elig & (~w_if_elig | (last_grant_q == c_FETCH));
  assign w_grant_if = (state_q == c_IDLE) & w_if_elig & (~w_dm_elig | (last_grant_q == c_DATA));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_grant_dm)      state_d = c_DM_WAIT;
        else if (w_grant_if) state_d = c_IF_WAIT;
      end
      c_DM_WAIT, c_IF_WAIT: begin
        if (bus.mem_done_i)                 state_d = c_IDLE;
        else if (wait_cnt_q == c_WAIT_LIMIT) state_d = c_ERR;
      end
      c_ERR:   state_d = c_ERR;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    err_d        = (state_d == c_ERR);
    case (state_q)
      c_IDLE: begin
        wait_cnt_d = 8'd0;
        if (w_grant_dm) begin
          mem_en_d     = 1'b1;
          mem_wr_d     = bus.dm_wr_i;
          mem_addr_d   = bus.dm_addr_i;
          mem_wdata_d  = bus.dm_wdata_i;
          last_grant_d = c_DATA;
        end else if (w_grant_if) begin
          mem_en_d     = 1'b1;
          mem_wr_d     = 1'b0;
          mem_addr_d   = bus.if_addr_i;
          mem_wdata_d  = bus.dm_wdata_i;
          last_grant_d = c_FETCH;
        end
      end
      c_DM_WAIT: begin
        if (bus.mem_done_i) begin
          dm_done_d  = 1'b1;
          wait_cnt_d = 8'd0;
          if (!mem_wr_q) dm_rdata_d = bus.mem_rdata_i;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      c_IF_WAIT: begin
        if (bus.mem_done_i) begin
          if_done_d  = 1'b1;
          wait_cnt_d = 8'd0;
          if_rdata_d = bus.mem_rdata_i;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= c_FETCH;
      wait_cnt_q   <= 8'd0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      if_rdata_q   <= 16'h0000;
      dm_rdata_q   <= 16'h0000;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_wr_o    = mem_wr_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.dm_done_o   = dm_done_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.err_o       = err_q;
  assign bus.if_stall_o  = (bus.if_req_i & ~if_done_q) | err_q;
  assign bus.dm_stall_o  = (bus.dm_req_i & ~dm_done_q) | err_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 16-bit pipeline.
- Memory latency is variable and signalled by mem_done.
- Grants one requester at a time and alternates grants under contention.
- Returns read data and a one-cycle done pulse to the owner of each transaction, and drives per-requester stall lines back to the pipeline.
- Aborts to a sticky error state if the memory never answers.

Parameters:
MAX_WAIT, 15, wait-state cycles after issue without mem_done before entering ERR (range 1..255)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
if_req  input  1  fetch read request, level, held until if_done
if_addr  input  16  fetch address
if_rdata  output  16  fetch read data, valid when if_done=1
if_done  output  1  one-cycle fetch completion pulse
if_stall  output  1  fetch must hold
dm_req  input  1  data request, level, held until dm_done
dm_wr  input  1  1=write, 0=read
dm_addr  input  16  data address
dm_wdata  input  16  write data
dm_rdata  output  16  data read data, valid when dm_done=1 on a read
dm_done  output  1  one-cycle data completion pulse
dm_stall  output  1  memory stage must hold
mem_en  output  1  one-cycle issue strobe to memory
mem_wr  output  1  write enable, held for the transaction
mem_addr  output  16  address, held for the transaction
mem_wdata  output  16  write data, held for the transaction
mem_rdata  input  16  memory read data, valid with mem_done
mem_done  input  1  memory completion
err  output  1  sticky timeout error

Behaviour:
- Reset (async, rst=1), all values immediate:
  - State = IDLE.
  - All outputs = 0, including rdata registers.
  - last_grant = FETCH.
  - Wait counter = 0.
- States: IDLE, DM_WAIT, IF_WAIT, ERR. All outputs are registered except the stall lines.
- IDLE, eligible requests:
  - A requester is eligible if its req=1 and its done is not asserted in this cycle.
  - A completing requester's req is ignored in its done cycle.
- IDLE, arbitration:
  - Both eligible: grant the one not equal to last_grant.
  - Otherwise grant the eligible one.
  - No request: stay in IDLE.
- On grant in cycle N:
  - Latch addr, wr (fetch forces wr=0) and wdata into mem_addr, mem_wr and mem_wdata.
  - Set last_grant.
  - Next state is DM_WAIT or IF_WAIT.
  - mem_en=1 in cycle N+1 only.
- In the WAIT states:
  - mem_addr, mem_wr and mem_wdata stay constant.
  - mem_done is sampled every cycle, including the mem_en cycle.
  - Requester inputs are ignored and may change.
- mem_done=1 in cycle M:
  - In cycle M+1, the owner's done=1 for exactly one cycle.
  - For a read, the owner's rdata = mem_rdata captured at M. rdata holds until the next read completion for that requester; a write leaves dm_rdata unchanged.
  - State returns to IDLE.
  - The wait counter clears.
  - Minimum latency is request to done = 2 cycles.
- Back-to-back transactions:
  - In cycle M+1, IDLE may grant the other requester.
  - The requester that just finished needs at least one cycle with req=0, or is re-eligible from M+2.
- Timeout:
  - The wait counter increments each WAIT cycle without mem_done.
  - If it reaches MAX_WAIT without mem_done, next state is ERR.
- ERR:
  - err=1 and stays until reset.
  - mem_en=0, no done pulses.
  - mem_done is ignored.
- Stall lines (combinational):
  - if_stall = (if_req & ~if_done) | err.
  - dm_stall = (dm_req & ~dm_done) | err.
- Reset mid-transaction abandons the transaction: no done pulse is produced and memory outputs drop to 0.

Test Plan:
- if_req=1, if_addr=0x0040; mem_done=1 two cycles after mem_en with mem_rdata=0xA5A5 -> mem_en pulses once with mem_addr=0x0040, mem_wr=0; if_done=1 one cycle later with if_rdata=0xA5A5; if_stall high until that cycle.
- if_req and dm_req rise together (dm_wr=1, dm_addr=0x1000, dm_wdata=0x1234) right after reset -> data is granted first (mem_wr=1, mem_wdata=0x1234); dm_done follows; fetch is granted in the dm_done cycle; dm_rdata stays 0.
- Both requesters re-request every cycle after completing -> grants strictly alternate DM, IF, DM, IF; neither requester gets two consecutive grants.
- mem_done asserted in the same cycle as mem_en -> done arrives 2 cycles after the request; mem_addr is stable throughout.
- With MAX_WAIT=15, mem_done is never asserted -> err=1 after 15 wait cycles; if_stall and dm_stall=1; later mem_done pulses are ignored; rst clears everything to 0.
- rst asserted asynchronously mid-DM_WAIT -> all outputs 0 immediately; no dm_done; after release a fresh fetch completes normally.
